// File: rtl/rng_post.sv
// rng_post: post-processing for a raw ALFSR entropy bit stream.
//   Synchronizes rng_in, runs a repetition-count health test on the raw
//   samples, whitens pairs with a von Neumann extractor and packs the emitted
//   bits MSB-first into bytes behind a single-entry valid/ready output register.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   rng_in               raw entropy bit (asynchronous to clk)
//   sample_en            take one raw sample this cycle
//   clr                  synchronous soft clear (wins over sample_en/byte_ready)
//   byte_ready           consumer ready
//   byte_out/byte_valid  whitened byte and its valid flag
//   health_fail          sticky repetition-count failure
//   overflow             sticky flag: a completed byte was dropped
//
// Whitener phase:
//   state     | meaning
//   PH_FIRST  | next sample is the first of a pair
//   PH_SECOND | next sample is compared against the stored first sample
module rng_post #(
   parameter int unsigned REP_LIMIT   = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rng_in,
   input  logic       sample_en,
   input  logic       clr,
   input  logic       byte_ready,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       health_fail,
   output logic       overflow
);

   typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_t;

   localparam logic [7:0] REP_LIM8 = 8'(REP_LIMIT);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   phase_t                 phase_q, phase_d;
   logic                   first_q, first_d;
   logic [6:0]             shreg_q, shreg_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [7:0]             rep_q, rep_d;
   logic                   prev_q, prev_d;
   logic                   health_q, health_d;
   logic                   ovf_q, ovf_d;
   logic [7:0]             out_q, out_d;
   logic                   valid_q, valid_d;

   logic       samp;
   logic       trip;
   logic [7:0] byte_new;

   assign samp = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], rng_in};
      phase_d  = phase_q;
      first_d  = first_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      rep_d    = rep_q;
      prev_d   = prev_q;
      health_d = health_q;
      ovf_d    = ovf_q;
      out_d    = out_q;
      valid_d  = valid_q;
      trip     = 1'b0;
      byte_new = {shreg_q, first_q};

      if (clr) begin
         phase_d  = PH_FIRST;
         shreg_d  = '0;
         cnt_d    = '0;
         rep_d    = '0;
         health_d = 1'b0;
         ovf_d    = 1'b0;
         valid_d  = 1'b0;
      end else begin
         if (valid_q && byte_ready) valid_d = 1'b0;

         if (sample_en) begin
            prev_d = samp;
            // rep_q == 0 marks the first sample after reset/clr
            if (rep_q == 8'd0 || samp != prev_q) rep_d = 8'd1;
            else if (rep_q != 8'hFF)             rep_d = rep_q + 8'd1;
            trip = (rep_d == REP_LIM8);
            if (trip) health_d = 1'b1;

            // the tripping sample itself never reaches the whitener
            if (!health_q && !trip) begin
               if (phase_q == PH_FIRST) begin
                  first_d = samp;
                  phase_d = PH_SECOND;
               end else begin
                  phase_d = PH_FIRST;
                  if (samp != first_q) begin
                     shreg_d = byte_new[6:0];
                     cnt_d   = cnt_q + 3'd1;
                     if (cnt_q == 3'd7) begin
                        if (!valid_q || byte_ready) begin
                           out_d   = byte_new;
                           valid_d = 1'b1;
                        end else begin
                           ovf_d = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         phase_q  <= PH_FIRST;
         first_q  <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         rep_q    <= '0;
         prev_q   <= 1'b0;
         health_q <= 1'b0;
         ovf_q    <= 1'b0;
         out_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         phase_q  <= phase_d;
         first_q  <= first_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         rep_q    <= rep_d;
         prev_q   <= prev_d;
         health_q <= health_d;
         ovf_q    <= ovf_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
      end
   end

   assign byte_out    = out_q;
   assign byte_valid  = valid_q;
   assign health_fail = health_q;
   assign overflow    = ovf_q;

endmodule

// File: doc/rng_post.md
RNG_POST -- requirements
Module: rng_post

Interface
REQ-001 Parameter REP_LIMIT, default 32, range 2..255: number of consecutive identical raw samples that trips the health test.
REQ-002 Parameter SYNC_STAGES, default 2, range 2..3: synchronizer depth on rng_in.
REQ-003 clk  input  1  system/digitalization clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rng_in  input  1  raw ALFSR digitalized bit; asynchronous to clk.
REQ-006 sample_en  input  1  synchronous strobe; one raw sample is taken per cycle it is high.
REQ-007 clr  input  1  synchronous soft clear.
REQ-008 byte_ready  input  1  consumer ready.
REQ-009 byte_out  output  8  whitened random byte.
REQ-010 byte_valid  output  1  byte_out holds an untransferred byte.
REQ-011 health_fail  output  1  sticky repetition-count failure flag.
REQ-012 overflow  output  1  sticky flag: a completed byte was dropped.

Function
REQ-013 rng_in SHALL pass through a SYNC_STAGES flop chain before any use; the sampled value is the last stage's value in a sample_en cycle.
REQ-014 Whitener SHALL be a von Neumann pair extractor with phase bit: phase 0 -> store sample as first, phase<=1; phase 1 -> compare with first, phase<=0.
REQ-015 Pair 01 SHALL emit bit 0, pair 10 SHALL emit bit 1 (emitted bit = first sample); pairs 00/11 SHALL emit nothing.
REQ-016 Packer SHALL shift emitted bits in at bit 0 (shift left, first-emitted bit ends in bit 7), with bit counter 0..7.
REQ-017 On the 8th emitted bit the completed byte SHALL be offered to the output register in the same cycle and the counter SHALL wrap to 0.
REQ-018 Output register: when empty, or when byte_valid&&byte_ready that cycle, the completed byte loads and byte_valid=1 next cycle.
REQ-019 If the output register is full and not transferring when a byte completes, the byte SHALL be discarded and overflow set; byte_out is unchanged.
REQ-020 Transfer occurs on byte_valid&&byte_ready; byte_valid SHALL deassert next cycle unless a new byte loads simultaneously; byte_out SHALL be stable while byte_valid=1 and ready=0.
REQ-021 Health test on raw samples: 8-bit rep counter =1 on first sample after reset/clr, increments when sample equals previous sample, reloads 1 otherwise, saturates.
REQ-022 When rep counter reaches REP_LIMIT, health_fail SHALL be set the next cycle and remain set until reset or clr.
REQ-023 While health_fail=1 the whitener and packer SHALL ignore sample_en; a byte already in the output register remains deliverable.
REQ-024 The sample that trips the health test SHALL NOT be used by the whitener.
REQ-025 clr SHALL clear phase, packer, bit counter, rep counter, health_fail, overflow, and byte_valid; synchronizer is not cleared.
REQ-026 clr SHALL take priority over sample_en and byte_ready in the same cycle; no transfer is counted.
REQ-027 Latency: rng_in edge to sampled use SYNC_STAGES cycles; 8th emitting sample_en edge to byte_valid=1 is 1 cycle.

Reset
REQ-028 With rst_n=0, immediately and asynchronously: byte_out=8'h00, byte_valid=0, health_fail=0, overflow=0, phase=0, bit counter=0, rep counter=0, synchronizer flops=0.
REQ-029 Reset asserted mid-byte or with byte_valid=1 SHALL discard all partial and held data; first sample after release starts a new pair.

Verification
REQ-030 Samples (pairs) 10,01,10,10,01,01,10,01, ready=1 -> byte_out=8'hB2 with byte_valid one cycle after 16th sample.
REQ-031 Pairs 00,11 interleaved with the REQ-030 pairs -> same 8'hB2, discarded pairs produce no bits.
REQ-032 ready=0, two full bytes produced -> first byte held, overflow=1 after second completion, byte_out still first byte; ready=1 then -> one transfer, byte_valid=0.
REQ-033 REP_LIMIT=32, rng_in held 1 for 32 samples -> health_fail=1 the cycle after the 32nd; further samples produce no bytes; clr -> health_fail=0, byte_valid=0.
REQ-034 Byte completion with byte_valid=1 and byte_ready=1 same cycle -> new byte loaded, byte_valid stays 1, overflow=0.
REQ-035 rst_n pulsed low asynchronously after 5 emitted bits -> all outputs zero at once; next 16 samples of REQ-030 yield 8'hB2.
